// File: rtl/usb_hub_upstream_arbiter.sv
// usb_hub_upstream_arbiter
// Round-robin arbiter sharing the hub's single upstream transmit path among
// the downstream ports. It holds each grant for one complete packet and then
// enforces an inter-packet gap before the next grant.
// Optional feature macro: USB_HUB_ARB_TIMEOUT_EN enables the grant timeout
// (timeout_err / timeout_idx). When the macro is undefined, both are tied to 0.

module usb_hub_upstream_arbiter #(
    parameter int NUM_USB_DEVICES = 4,
    parameter int IDX_W           = (NUM_USB_DEVICES > 1) ? $clog2(NUM_USB_DEVICES) : 1,
    parameter int IPG_CYCLES      = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       hi_clock,
    input  logic                       reset_n,
    input  logic [NUM_USB_DEVICES-1:0] port_req,
    input  logic [NUM_USB_DEVICES-1:0] port_enable,
    input  logic                       pkt_start,
    input  logic                       pkt_eop,
    output logic [NUM_USB_DEVICES-1:0] port_grant,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       arb_busy,
    output logic                       timeout_err,
    output logic [IDX_W-1:0]           timeout_idx
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam int GAP_W    = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam int GAP_LAST = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;

    // Reject configurations the arbiter cannot implement
    if (NUM_USB_DEVICES < 1 || TIMEOUT_CYCLES < 1 || IPG_CYCLES < 0) begin : g_bad_param
        $error("usb_hub_upstream_arbiter: illegal parameter value");
    end

    state_e                     state_q, state_d;
    logic [NUM_USB_DEVICES-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]           grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]           last_idx_q, last_idx_d;
    logic                       busy_q, busy_d;
    logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;

    logic [NUM_USB_DEVICES-1:0] eff_req;
    logic                       granted_req;
    logic                       hi_found, lo_found, win_found;
    logic [IDX_W-1:0]           hi_idx, lo_idx, win_idx;
    logic [NUM_USB_DEVICES-1:0] win_onehot;
    logic                       to_expired;

    assign eff_req     = port_req & port_enable;
    assign granted_req = |(eff_req & grant_q);

    // Rotating-priority search: lowest requester above last_idx wins, else wrap to the lowest overall
    always_comb begin
        hi_found   = 1'b0;
        hi_idx     = '0;
        lo_found   = 1'b0;
        lo_idx     = '0;
        win_onehot = '0;
        for (int j = NUM_USB_DEVICES - 1; j >= 0; j--) begin
            if (eff_req[j]) begin
                if (IDX_W'(j) > last_idx_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(j);
                end
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
        for (int j = 0; j < NUM_USB_DEVICES; j++) begin
            win_onehot[j] = (IDX_W'(j) == win_idx);
        end
    end

    // Next-state logic; in GRANT, pkt_start beats a request drop, which beats timeout
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d     = ST_GRANT;
                    grant_d     = win_onehot;
                    grant_idx_d = win_idx;
                    last_idx_d  = win_idx;
                end
            end
            ST_GRANT: begin
                if (pkt_start) begin
                    if (pkt_eop) begin
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        if (IPG_CYCLES > 0) state_d = ST_GAP;
                        else                state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (!granted_req) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (to_expired) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (pkt_eop) begin
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    if (IPG_CYCLES > 0) state_d = ST_GAP;
                    else                state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = ST_IDLE;
                else                                gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_GRANT) || (state_d == ST_ACTIVE);
    end

    // Arbiter state register; reset leaves port 0 with first priority
    always_ff @(posedge hi_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(NUM_USB_DEVICES - 1);
            busy_q      <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            busy_q      <= busy_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign port_grant = grant_q;
    assign grant_idx  = grant_idx_q;
    assign arb_busy   = busy_q;

`ifdef USB_HUB_ARB_TIMEOUT_EN
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             to_err_q, to_err_d;
    logic [IDX_W-1:0] to_idx_q, to_idx_d;
    logic             timeout_now;

    // Count cycles spent in GRANT; the count restarts from zero on every entry
    always_comb begin
        to_expired  = (state_q == ST_GRANT) && (to_cnt_q == TO_W'(TO_LAST));
        timeout_now = (state_q == ST_GRANT) && !pkt_start && granted_req && to_expired;
        to_cnt_d    = (state_q == ST_GRANT) ? to_cnt_q + TO_W'(1) : '0;
        to_err_d    = timeout_now;
        to_idx_d    = timeout_now ? grant_idx_q : to_idx_q;
    end

    // Timeout counter, error pulse and sticky index of the port that timed out
    always_ff @(posedge hi_clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
            to_idx_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
            to_idx_q <= to_idx_d;
        end
    end

    assign timeout_err = to_err_q;
    assign timeout_idx = to_idx_q;
`else
    assign to_expired  = 1'b0;
    assign timeout_err = 1'b0;
    assign timeout_idx = '0;
`endif

endmodule

// File: tb/tb_usb_hub_upstream_arbiter.sv
// Testbench for usb_hub_upstream_arbiter.
// Two instances share all inputs: one with an 8-cycle gap, one with no gap.
// Timeout behaviour is checked when USB_HUB_ARB_TIMEOUT_EN is defined,
// otherwise the indefinite-wait behaviour is checked.

module tb_usb_hub_upstream_arbiter;

    logic       hi_clock;
    logic       reset_n;
    logic [3:0] port_req;
    logic [3:0] port_enable;
    logic       pkt_start;
    logic       pkt_eop;

    logic [3:0] port_grant;
    logic [1:0] grant_idx;
    logic       arb_busy;
    logic       timeout_err;
    logic [1:0] timeout_idx;

    logic [3:0] ng_grant;
    logic [1:0] ng_idx;
    logic       ng_busy;
    logic       ng_terr;
    logic [1:0] ng_tidx;

    int checks;
    int fails;

    usb_hub_upstream_arbiter #(
        .NUM_USB_DEVICES(4),
        .IDX_W(2),
        .IPG_CYCLES(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .hi_clock(hi_clock),
        .reset_n(reset_n),
        .port_req(port_req),
        .port_enable(port_enable),
        .pkt_start(pkt_start),
        .pkt_eop(pkt_eop),
        .port_grant(port_grant),
        .grant_idx(grant_idx),
        .arb_busy(arb_busy),
        .timeout_err(timeout_err),
        .timeout_idx(timeout_idx)
    );

    usb_hub_upstream_arbiter #(
        .NUM_USB_DEVICES(4),
        .IDX_W(2),
        .IPG_CYCLES(0),
        .TIMEOUT_CYCLES(16)
    ) dut_nogap (
        .hi_clock(hi_clock),
        .reset_n(reset_n),
        .port_req(port_req),
        .port_enable(port_enable),
        .pkt_start(pkt_start),
        .pkt_eop(pkt_eop),
        .port_grant(ng_grant),
        .grant_idx(ng_idx),
        .arb_busy(ng_busy),
        .timeout_err(ng_terr),
        .timeout_idx(ng_tidx)
    );

    // 10 ns clock
    initial begin
        hi_clock = 1'b0;
        forever #5 hi_clock = ~hi_clock;
    end

    // Advance one rising edge and settle 1 ns past it
    task automatic tick();
        @(posedge hi_clock);
        #1;
    endtask

    // Put both instances into reset with quiet inputs, then release
    task automatic do_reset();
        reset_n     = 1'b0;
        port_req    = 4'b0000;
        port_enable = 4'b1111;
        pkt_start   = 1'b0;
        pkt_eop     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        port_req    = 4'b0000;
        port_enable = 4'b1111;
        pkt_start   = 1'b0;
        pkt_eop     = 1'b0;
        tick();
        checks++; if (port_grant !== 4'b0000) begin fails++; $display("[TB] FAIL reset_grant: got %b expected %b", port_grant, 4'b0000); end
        checks++; if (grant_idx !== 2'd0) begin fails++; $display("[TB] FAIL reset_idx: got %0d expected 0", grant_idx); end
        checks++; if (arb_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", arb_busy); end
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_terr: got %b expected 0", timeout_err); end
        checks++; if (timeout_idx !== 2'd0) begin fails++; $display("[TB] FAIL reset_tidx: got %0d expected 0", timeout_idx); end
        reset_n = 1'b1;
        port_req = 4'b0100;
        tick();
        checks++; if (port_grant !== 4'b0100) begin fails++; $display("[TB] FAIL reset_p2_grant: got %b expected %b", port_grant, 4'b0100); end
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        checks++; if (arb_busy !== 1'b1) begin fails++; $display("[TB] FAIL reset_p2_active: got %b expected 1", arb_busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (port_grant !== 4'b0000) begin fails++; $display("[TB] FAIL async_reset_grant: got %b expected %b", port_grant, 4'b0000); end
        checks++; if (arb_busy !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_busy: got %b expected 0", arb_busy); end
        reset_n  = 1'b1;
        port_req = 4'b1001;
        tick();
        checks++; if (port_grant !== 4'b0001) begin fails++; $display("[TB] FAIL post_reset_grant: got %b expected %b", port_grant, 4'b0001); end
        checks++; if (grant_idx !== 2'd0) begin fails++; $display("[TB] FAIL post_reset_idx: got %0d expected 0", grant_idx); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_grant;
        int n;
        do_reset();
        port_req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_grant = 4'b0001 << (k % 4);
            checks++; if (port_grant !== exp_grant) begin fails++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, port_grant, exp_grant); end
            checks++; if (grant_idx !== 2'(k % 4)) begin fails++; $display("[TB] FAIL rr_idx_%0d: got %0d expected %0d", k, grant_idx, k % 4); end
            checks++; if (arb_busy !== 1'b1) begin fails++; $display("[TB] FAIL rr_busy_%0d: got %b expected 1", k, arb_busy); end
            if (k < 4) begin
                pkt_start = 1'b1;
                tick();
                pkt_start = 1'b0;
                tick();
                pkt_eop = 1'b1;
                tick();
                pkt_eop = 1'b0;
                checks++; if (port_grant !== 4'b0000) begin fails++; $display("[TB] FAIL rr_eop_clear_%0d: got %b expected %b", k, port_grant, 4'b0000); end
                n = 0;
                while (port_grant === 4'b0000 && n < 20) begin
                    tick();
                    n++;
                end
                checks++; if (n !== 9) begin fails++; $display("[TB] FAIL rr_gap_%0d: got %0d cycles expected 9", k, n); end
            end
        end
    endtask

    task automatic test_no_truncation();
        do_reset();
        port_req = 4'b0010;
        tick();
        checks++; if (port_grant !== 4'b0010) begin fails++; $display("[TB] FAIL nt_grant: got %b expected %b", port_grant, 4'b0010); end
        pkt_start = 1'b1;
        tick();
        pkt_start   = 1'b0;
        port_req    = 4'b0000;
        port_enable = 4'b1101;
        repeat (5) tick();
        checks++; if (port_grant !== 4'b0010) begin fails++; $display("[TB] FAIL nt_hold: got %b expected %b", port_grant, 4'b0010); end
        checks++; if (arb_busy !== 1'b1) begin fails++; $display("[TB] FAIL nt_busy: got %b expected 1", arb_busy); end
        pkt_eop = 1'b1;
        tick();
        pkt_eop = 1'b0;
        checks++; if (port_grant !== 4'b0000) begin fails++; $display("[TB] FAIL nt_eop: got %b expected %b", port_grant, 4'b0000); end

        do_reset();
        port_enable = 4'b0111;
        port_req    = 4'b1000;
        repeat (20) tick();
        checks++; if (port_grant !== 4'b0000) begin fails++; $display("[TB] FAIL nt_disabled: got %b expected %b", port_grant, 4'b0000); end
        checks++; if (arb_busy !== 1'b0) begin fails++; $display("[TB] FAIL nt_disabled_busy: got %b expected 0", arb_busy); end
        port_req = 4'b1010;
        tick();
        checks++; if (port_grant !== 4'b0010) begin fails++; $display("[TB] FAIL nt_enabled_win: got %b expected %b", port_grant, 4'b0010); end
        port_enable = 4'b1111;
    endtask

`ifdef USB_HUB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic seen;
        do_reset();
        port_req = 4'b0110;
        tick();
        checks++; if (port_grant !== 4'b0010) begin fails++; $display("[TB] FAIL to_grant: got %b expected %b", port_grant, 4'b0010); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (timeout_err !== 1'b0 || port_grant !== 4'b0010) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL to_early: got %b expected 0", seen); end
        tick();
        checks++; if (port_grant !== 4'b0000) begin fails++; $display("[TB] FAIL to_clear: got %b expected %b", port_grant, 4'b0000); end
        checks++; if (timeout_err !== 1'b1) begin fails++; $display("[TB] FAIL to_pulse: got %b expected 1", timeout_err); end
        checks++; if (timeout_idx !== 2'd1) begin fails++; $display("[TB] FAIL to_idx: got %0d expected 1", timeout_idx); end
        checks++; if (arb_busy !== 1'b0) begin fails++; $display("[TB] FAIL to_busy: got %b expected 0", arb_busy); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL to_pulse_end: got %b expected 0", timeout_err); end
        checks++; if (port_grant !== 4'b0100) begin fails++; $display("[TB] FAIL to_next: got %b expected %b", port_grant, 4'b0100); end
        checks++; if (timeout_idx !== 2'd1) begin fails++; $display("[TB] FAIL to_idx_hold: got %0d expected 1", timeout_idx); end
    endtask
`else
    task automatic test_no_timeout();
        logic seen;
        do_reset();
        port_req = 4'b0011;
        tick();
        checks++; if (port_grant !== 4'b0001) begin fails++; $display("[TB] FAIL nto_grant: got %b expected %b", port_grant, 4'b0001); end
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (timeout_err !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL nto_err: got %b expected 0", seen); end
        checks++; if (port_grant !== 4'b0001) begin fails++; $display("[TB] FAIL nto_hold: got %b expected %b", port_grant, 4'b0001); end
        port_req = 4'b0010;
        tick();
        checks++; if (port_grant !== 4'b0000) begin fails++; $display("[TB] FAIL nto_drop: got %b expected %b", port_grant, 4'b0000); end
        checks++; if (arb_busy !== 1'b0) begin fails++; $display("[TB] FAIL nto_drop_busy: got %b expected 0", arb_busy); end
        tick();
        checks++; if (port_grant !== 4'b0010) begin fails++; $display("[TB] FAIL nto_next: got %b expected %b", port_grant, 4'b0010); end
    endtask
`endif

    task automatic test_same_cycle_start_eop();
        int n;
        do_reset();
        port_req = 4'b0011;
        tick();
        checks++; if (ng_grant !== 4'b0001) begin fails++; $display("[TB] FAIL sc_grant: got %b expected %b", ng_grant, 4'b0001); end
        pkt_start = 1'b1;
        pkt_eop   = 1'b1;
        tick();
        pkt_start = 1'b0;
        pkt_eop   = 1'b0;
        checks++; if (ng_grant !== 4'b0000) begin fails++; $display("[TB] FAIL sc_clear: got %b expected %b", ng_grant, 4'b0000); end
        checks++; if (ng_busy !== 1'b0) begin fails++; $display("[TB] FAIL sc_busy: got %b expected 0", ng_busy); end
        checks++; if (port_grant !== 4'b0000) begin fails++; $display("[TB] FAIL sc_gap_clear: got %b expected %b", port_grant, 4'b0000); end
        tick();
        checks++; if (ng_grant !== 4'b0010) begin fails++; $display("[TB] FAIL sc_next: got %b expected %b", ng_grant, 4'b0010); end
        checks++; if (ng_idx !== 2'd1) begin fails++; $display("[TB] FAIL sc_next_idx: got %0d expected 1", ng_idx); end
        n = 0;
        while (port_grant === 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n !== 8) begin fails++; $display("[TB] FAIL sc_gap8: got %0d cycles expected 8", n); end
        checks++; if (port_grant !== 4'b0010) begin fails++; $display("[TB] FAIL sc_gap8_grant: got %b expected %b", port_grant, 4'b0010); end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        checks = 0;
        fails  = 0;
        $display("[TB] starting usb_hub_upstream_arbiter bench");
        test_reset();
        test_round_robin();
        test_no_truncation();
`ifdef USB_HUB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_same_cycle_start_eop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
